// File: rtl/lcd_pkg.sv
// Shared types and widths for the LCD panel init command sequencer.
package lcd_pkg;

  localparam int unsigned OP_W           = 2;
  localparam int unsigned DEFAULT_WORD_W = 8;
  localparam int unsigned ENTRY_W        = OP_W + DEFAULT_WORD_W;

  typedef enum logic [OP_W-1:0] {
    OP_CMD = 2'd0,
    OP_DAT = 2'd1,
    OP_DLY = 2'd2,
    OP_END = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HWRST_LO,
    ST_HWRST_WAIT,
    ST_FETCH,
    ST_EXEC,
    ST_SEND,
    ST_DELAY,
    ST_FIN
  } seq_state_e;

endpackage

// File: rtl/lcd_init_rom.sv
// Registered sequence table; entry i sits at CONTENTS[i*WIDTH +: WIDTH], op in the top bits.
module lcd_init_rom
  import lcd_pkg::*;
#(
  parameter int unsigned ROM_DEPTH = 32,
  parameter int unsigned WIDTH     = ENTRY_W,
  parameter int unsigned ADDR_W    = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1,
  parameter logic [ROM_DEPTH*WIDTH-1:0] CONTENTS = '1
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [WIDTH-1:0]  q
);

  logic [WIDTH-1:0] mem [ROM_DEPTH];

  for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_mem
    assign mem[i] = CONTENTS[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    q <= mem[addr];
  end

endmodule

// File: rtl/lcd_cmd_seq.sv
// Panel bring-up sequencer: hardware reset pulse, then walks the command table
// emitting CMD/DAT bytes over valid/ready and honouring millisecond delays.
module lcd_cmd_seq
  import lcd_pkg::*;
#(
  parameter int unsigned WORD_WIDTH   = 8,
  parameter int unsigned ROM_DEPTH    = 32,
  parameter int unsigned TICKS_PER_MS = 27000,
  parameter int unsigned RST_LOW_MS   = 10,
  parameter int unsigned RST_WAIT_MS  = 120,
  parameter logic [ROM_DEPTH*(OP_W+WORD_WIDTH)-1:0] INIT_TABLE = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  valid,
  input  logic                  ready,
  output logic [WORD_WIDTH-1:0] data,
  output logic                  dc,
  output logic                  lcd_rst_n
);

  localparam int unsigned EW   = OP_W + WORD_WIDTH;
  localparam int unsigned TW   = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int unsigned RWW  = $clog2(RST_WAIT_MS + 1);
  localparam int unsigned MW   = (WORD_WIDTH > RWW) ? WORD_WIDTH : RWW;
  localparam int unsigned AW   = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(ROM_DEPTH - 1);

  seq_state_e            state, state_nx;
  logic [AW-1:0]         ptr, ptr_nx;
  logic [TW-1:0]         tick, tick_nx, tick_step;
  logic [MW-1:0]         ms, ms_nx, ms_step;
  logic [WORD_WIDTH-1:0] data_nx;
  logic                  dc_nx;
  logic                  tick_wrap, timer_done;
  logic [EW-1:0]         rom_q;
  op_e                   op;
  logic [WORD_WIDTH-1:0] arg;
  seq_state_e            adv_state;
  logic [AW-1:0]         adv_ptr;

  lcd_init_rom #(
    .ROM_DEPTH (ROM_DEPTH),
    .WIDTH     (EW),
    .ADDR_W    (AW),
    .CONTENTS  (INIT_TABLE)
  ) u_rom (
    .clk  (clk),
    .addr (ptr),
    .q    (rom_q)
  );

  assign op  = op_e'(rom_q[EW-1 -: OP_W]);
  assign arg = rom_q[WORD_WIDTH-1:0];

  // Shared ms timer: ticks wrap each millisecond, ms counts down to the last one.
  assign tick_wrap  = (tick == TW'(TICKS_PER_MS - 1));
  assign timer_done = tick_wrap && (ms <= MW'(1));
  assign tick_step  = tick_wrap ? '0 : tick + TW'(1);
  assign ms_step    = tick_wrap ? ms - MW'(1) : ms;

  // The final table slot ends the sequence even without an END entry.
  assign adv_state = (ptr == LAST) ? ST_FIN : ST_FETCH;
  assign adv_ptr   = (ptr == LAST) ? ptr : ptr + AW'(1);

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    tick_nx  = tick;
    ms_nx    = ms;
    data_nx  = data;
    dc_nx    = dc;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_HWRST_LO;
          tick_nx  = '0;
          ms_nx    = MW'(RST_LOW_MS);
        end
      end
      ST_HWRST_LO: begin
        tick_nx = tick_step;
        ms_nx   = ms_step;
        if (timer_done) begin
          state_nx = ST_HWRST_WAIT;
          tick_nx  = '0;
          ms_nx    = MW'(RST_WAIT_MS);
        end
      end
      ST_HWRST_WAIT: begin
        tick_nx = tick_step;
        ms_nx   = ms_step;
        if (timer_done) begin
          state_nx = ST_FETCH;
          ptr_nx   = '0;
        end
      end
      ST_FETCH: state_nx = ST_EXEC;
      ST_EXEC: begin
        case (op)
          OP_CMD, OP_DAT: begin
            data_nx  = arg;
            dc_nx    = (op == OP_DAT);
            state_nx = ST_SEND;
          end
          OP_DLY: begin
            if (arg == '0) begin
              state_nx = adv_state;
              ptr_nx   = adv_ptr;
            end else begin
              state_nx = ST_DELAY;
              tick_nx  = '0;
              ms_nx    = MW'(arg);
            end
          end
          OP_END: state_nx = ST_FIN;
          default: state_nx = ST_FIN;
        endcase
      end
      ST_SEND: begin
        if (ready) begin
          state_nx = adv_state;
          ptr_nx   = adv_ptr;
        end
      end
      ST_DELAY: begin
        tick_nx = tick_step;
        ms_nx   = ms_step;
        if (timer_done) begin
          state_nx = adv_state;
          ptr_nx   = adv_ptr;
        end
      end
      ST_FIN:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      tick      <= '0;
      ms        <= '0;
      data      <= '0;
      dc        <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      lcd_rst_n <= 1'b1;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      tick      <= tick_nx;
      ms        <= ms_nx;
      data      <= data_nx;
      dc        <= dc_nx;
      valid     <= (state_nx == ST_SEND);
      busy      <= (state_nx != ST_IDLE);
      done      <= (state_nx == ST_FIN);
      lcd_rst_n <= (state_nx != ST_HWRST_LO);
    end
  end

endmodule

// File: doc/lcd_cmd_seq.md
LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8: payload byte width; matches the downstream serializer word.
REQ-002 SHALL have parameter ROM_DEPTH, default 32: number of sequence-table entries.
REQ-003 SHALL have parameter TICKS_PER_MS, default 27000: clk cycles per millisecond.
REQ-004 SHALL have parameter RST_LOW_MS, default 10: panel reset assertion time, in ms.
REQ-005 SHALL have parameter RST_WAIT_MS, default 120: post-reset settle time, in ms.
REQ-006 SHALL have port clk, input, 1 bit: sole clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: one-cycle request to run the sequence.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when the sequence completes.
REQ-011 SHALL have port valid, output, 1 bit: data word available downstream.
REQ-012 SHALL have port ready, input, 1 bit: downstream serializer accepts the word.
REQ-013 SHALL have port data, output, WORD_WIDTH bits: byte to serialize.
REQ-014 SHALL have port dc, output, 1 bit: panel D/C line; 0 = command, 1 = data.
REQ-015 SHALL have port lcd_rst_n, output, 1 bit: panel hardware reset, active-low.

Function
REQ-016 Table entry SHALL be {op[1:0], arg[WORD_WIDTH-1:0]}, with op in {CMD, DAT, DLY, END}.
REQ-017 The ROM SHALL have synchronous read with 1-cycle latency; the address is the pointer ptr.
REQ-018 The FSM SHALL have states IDLE, HWRST_LO, HWRST_WAIT, FETCH, EXEC, SEND, DELAY, FIN.
REQ-019 IDLE SHALL move to HWRST_LO on start; start SHALL be ignored in any other state.
REQ-020 HWRST_LO SHALL drive lcd_rst_n=0 for exactly RST_LOW_MS*TICKS_PER_MS cycles, then go to HWRST_WAIT.
REQ-021 HWRST_WAIT SHALL drive lcd_rst_n=1 for RST_WAIT_MS*TICKS_PER_MS cycles, then set ptr=0 and go to FETCH.
REQ-022 FETCH SHALL present ptr to the ROM for one cycle, then go to EXEC.
REQ-023 EXEC with CMD or DAT SHALL load data=arg and dc=(op==DAT), then go to SEND.
REQ-024 EXEC with DLY SHALL load the ms counter with arg and go to DELAY; arg=0 SHALL skip DELAY and go to FETCH with ptr+1.
REQ-025 EXEC with END SHALL go to FIN.
REQ-026 SEND SHALL hold valid=1 with data and dc stable until valid&&ready is sampled.
REQ-027 On the SEND handshake, valid SHALL drop the next cycle, ptr SHALL increment, and the FSM SHALL go to FETCH; there is no back-to-back streaming, and 2 idle cycles SHALL separate each handshake.
REQ-028 dc and data SHALL retain their last values outside SEND, so the D/C line stays valid while the serializer shifts the byte.
REQ-029 DELAY SHALL last exactly arg*TICKS_PER_MS cycles, then go to FETCH with ptr+1.
REQ-030 If ptr==ROM_DEPTH-1 and the entry is not END, that entry SHALL execute and then be treated as END; ptr SHALL never wrap.
REQ-031 FIN SHALL assert done for exactly one cycle, then go to IDLE.
REQ-032 A start in the same cycle as done SHALL be ignored.
REQ-033 Tick counter width SHALL be $clog2(TICKS_PER_MS); ms counter width SHALL be max(WORD_WIDTH, $clog2(RST_WAIT_MS+1)); no overflow is permitted for legal parameters.

Reset
REQ-034 rst SHALL force asynchronously: state=IDLE, ptr=0, counters=0, valid=0, data=0, dc=0, done=0, busy=0, lcd_rst_n=1.
REQ-035 rst asserted mid-SEND SHALL drop valid immediately, with no handshake completed.
REQ-036 After rst deasserts, the block SHALL wait in IDLE for a new start.

Structure
REQ-037 Package lcd_pkg SHALL hold: the op enum (CMD=0, DAT=1, DLY=2, END=3), the seq state enum, and the entry-width constant.
REQ-038 Sub-module lcd_init_rom SHALL hold the registered table (initial-block or $readmemh contents) and be parameterized by ROM_DEPTH and entry width.
REQ-039 The rest of the FSM and counters SHALL live in lcd_cmd_seq with separate next-state combinational logic; the downstream serializer SHALL connect directly via valid/ready/data.

Verification (TICKS_PER_MS=4, RST_LOW_MS=1, RST_WAIT_MS=2 for sim)
REQ-040 Basic run: start pulse → lcd_rst_n low for 4 cycles, high for 8 cycles, then the first FETCH; busy high from the cycle after start.
REQ-041 Table {CMD 0x11, DLY 3, DAT 0xA5, END} with ready tied 1 → bytes 0x11 (dc=0) then 0xA5 (dc=1); exactly 12 cycles between the two valid rises beyond fetch overhead; one done pulse.
REQ-042 Backpressure: ready held 0 for 10 cycles during SEND → valid, data and dc constant throughout; exactly one handshake once ready=1.
REQ-043 Edge entries: DLY 0 → no DELAY cycles spent; table with no END → last entry executes, done pulses, ptr never wraps.
REQ-044 Reset during SEND with valid=1 → valid=0, lcd_rst_n=1, busy=0 asynchronously; a subsequent start replays from entry 0.
REQ-045 start pulsed while busy and in the done cycle → ignored; exactly one sequence executes.
